// File: rtl/clock_hms_counter.sv
// clock_hms_counter: BCD hours/minutes/seconds time-of-day counter.
// A prescaler divides clk by DIV = SYS_CLK_HZ/TICK_HZ to form the seconds
// tick. The time can be cleared, loaded (with a validity check) or counted.
//
// Parameters:
//   SYS_CLK_HZ - system clock frequency in Hz
//   TICK_HZ    - seconds-tick rate in Hz
//   HOUR_MAX   - hour modulus, 12 or 24
// Ports:
//   clk, reset_p        - clock, asynchronous active-high reset
//   run                 - count enable (prescaler holds when low)
//   clear               - synchronous zero of time and prescaler
//   load                - load strobe for ld_hr/ld_min/ld_sec (BCD)
//   sec1..hr10          - BCD digit outputs
//   tick_sec/min/hr     - one-cycle carry pulses
//   load_err            - one-cycle pulse on a rejected load/alarm_set
// Optional feature (macro CLOCK_HMS_ALARM_EN):
//   alarm_on, alarm_set, al_min, al_hr in; alarm_hit out.
module clock_hms_counter #(
    parameter int unsigned SYS_CLK_HZ = 100000000,
    parameter int unsigned TICK_HZ    = 1,
    parameter int unsigned HOUR_MAX   = 24
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       run,
    input  logic       clear,
    input  logic       load,
    input  logic [7:0] ld_sec,
    input  logic [7:0] ld_min,
    input  logic [7:0] ld_hr,
`ifdef CLOCK_HMS_ALARM_EN
    input  logic       alarm_on,
    input  logic       alarm_set,
    input  logic [7:0] al_min,
    input  logic [7:0] al_hr,
    output logic       alarm_hit,
`endif
    output logic [3:0] sec1,
    output logic [3:0] sec10,
    output logic [3:0] min1,
    output logic [3:0] min10,
    output logic [3:0] hr1,
    output logic [3:0] hr10,
    output logic       tick_sec,
    output logic       tick_min,
    output logic       tick_hr,
    output logic       load_err
);

    localparam int unsigned TICK_SAFE = (TICK_HZ == 0) ? 1 : TICK_HZ;
    localparam int unsigned DIV       = SYS_CLK_HZ / TICK_SAFE;
    localparam int unsigned PW        = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX    = PW'(DIV - 1);
    localparam logic [7:0] HR_LIMIT   = 8'(HOUR_MAX);
    localparam logic [7:0] HR_LAST    = 8'(HOUR_MAX - 1);

    // Elaboration-time parameter legality
    if (TICK_HZ == 0 || (SYS_CLK_HZ % TICK_SAFE) != 0 || DIV < 2) begin : g_bad_div
        $error("clock_hms_counter: SYS_CLK_HZ/TICK_HZ must be integral and >= 2");
    end
    if (HOUR_MAX != 12 && HOUR_MAX != 24) begin : g_bad_hour
        $error("clock_hms_counter: HOUR_MAX must be 12 or 24");
    end

    // Binary value of a two-digit BCD byte (only meaningful when both digits <= 9)
    function automatic logic [7:0] bcd_val(input logic [7:0] b);
        return 8'(b[7:4]) * 8'd10 + 8'(b[3:0]);
    endfunction

    // A time value is legal when every digit is BCD, tens of min/sec <= 5, hour < HOUR_MAX
    function automatic logic time_ok(input logic [7:0] h, input logic [7:0] m,
                                     input logic [7:0] s);
        logic digits_ok;
        digits_ok = (h[7:4] <= 4'd9) && (h[3:0] <= 4'd9) &&
                    (m[3:0] <= 4'd9) && (s[3:0] <= 4'd9) &&
                    (m[7:4] <= 4'd5) && (s[7:4] <= 4'd5);
        return digits_ok && (bcd_val(h) < HR_LIMIT);
    endfunction

    logic [PW-1:0] presc_q, presc_d;
    logic [3:0]    sec1_d, sec10_d, min1_d, min10_d, hr1_d, hr10_d;
    logic          tick_sec_d, tick_min_d, tick_hr_d, load_err_d;
    logic          ld_ok, al_err, upd_d;

    assign ld_ok = time_ok(ld_hr, ld_min, ld_sec);

`ifdef CLOCK_HMS_ALARM_EN
    logic [7:0] al_min_q, al_hr_q;
    logic       al_ok, upd_q;
    assign al_ok  = time_ok(al_hr, al_min, 8'h00);
    assign al_err = alarm_set && !al_ok;
`else
    assign al_err = 1'b0;
`endif

    // Next-state: clear > load > prescaler tick; ripple BCD carry chain
    always_comb begin
        presc_d    = presc_q;
        sec1_d     = sec1;
        sec10_d    = sec10;
        min1_d     = min1;
        min10_d    = min10;
        hr1_d      = hr1;
        hr10_d     = hr10;
        tick_sec_d = 1'b0;
        tick_min_d = 1'b0;
        tick_hr_d  = 1'b0;
        load_err_d = 1'b0;
        upd_d      = 1'b0;

        if (clear) begin
            presc_d = '0;
            sec1_d  = 4'd0;
            sec10_d = 4'd0;
            min1_d  = 4'd0;
            min10_d = 4'd0;
            hr1_d   = 4'd0;
            hr10_d  = 4'd0;
        end else begin
            if (load) begin
                if (ld_ok) begin
                    presc_d = '0;
                    sec1_d  = ld_sec[3:0];
                    sec10_d = ld_sec[7:4];
                    min1_d  = ld_min[3:0];
                    min10_d = ld_min[7:4];
                    hr1_d   = ld_hr[3:0];
                    hr10_d  = ld_hr[7:4];
                    upd_d   = 1'b1;
                end else begin
                    load_err_d = 1'b1;
                end
            end else if (run) begin
                if (presc_q == PMAX) begin
                    presc_d    = '0;
                    tick_sec_d = 1'b1;
                    upd_d      = 1'b1;
                    if (sec1 != 4'd9) begin
                        sec1_d = sec1 + 4'd1;
                    end else begin
                        sec1_d = 4'd0;
                        if (sec10 != 4'd5) begin
                            sec10_d = sec10 + 4'd1;
                        end else begin
                            // Seconds wrap: minutes advance on the same edge
                            sec10_d    = 4'd0;
                            tick_min_d = 1'b1;
                            if (min1 != 4'd9) begin
                                min1_d = min1 + 4'd1;
                            end else begin
                                min1_d = 4'd0;
                                if (min10 != 4'd5) begin
                                    min10_d = min10 + 4'd1;
                                end else begin
                                    min10_d   = 4'd0;
                                    tick_hr_d = 1'b1;
                                    if (bcd_val({hr10, hr1}) == HR_LAST) begin
                                        hr1_d  = 4'd0;
                                        hr10_d = 4'd0;
                                    end else if (hr1 == 4'd9) begin
                                        hr1_d  = 4'd0;
                                        hr10_d = hr10 + 4'd1;
                                    end else begin
                                        hr1_d = hr1 + 4'd1;
                                    end
                                end
                            end
                        end
                    end
                end else begin
                    presc_d = presc_q + PW'(1);
                end
            end
            if (al_err) begin
                load_err_d = 1'b1;
            end
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            presc_q  <= '0;
            sec1     <= 4'd0;
            sec10    <= 4'd0;
            min1     <= 4'd0;
            min10    <= 4'd0;
            hr1      <= 4'd0;
            hr10     <= 4'd0;
            tick_sec <= 1'b0;
            tick_min <= 1'b0;
            tick_hr  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            presc_q  <= presc_d;
            sec1     <= sec1_d;
            sec10    <= sec10_d;
            min1     <= min1_d;
            min10    <= min10_d;
            hr1      <= hr1_d;
            hr10     <= hr10_d;
            tick_sec <= tick_sec_d;
            tick_min <= tick_min_d;
            tick_hr  <= tick_hr_d;
            load_err <= load_err_d;
        end
    end

`ifdef CLOCK_HMS_ALARM_EN
    // Alarm store and match; upd_q marks that the time was just written by count or load
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            al_min_q  <= 8'h00;
            al_hr_q   <= 8'h00;
            upd_q     <= 1'b0;
            alarm_hit <= 1'b0;
        end else begin
            if (alarm_set && al_ok) begin
                al_min_q <= al_min;
                al_hr_q  <= al_hr;
            end
            upd_q     <= upd_d;
            alarm_hit <= alarm_on && upd_q &&
                         ({sec10, sec1} == 8'h00) &&
                         ({min10, min1} == al_min_q) &&
                         ({hr10, hr1} == al_hr_q);
        end
    end
`else
    logic unused_upd;
    assign unused_upd = upd_d;
`endif

endmodule

// File: tb/tb_clock_hms_counter.sv
// tb_clock_hms_counter: scoreboard bench for clock_hms_counter (DIV = 10).
// dut_a runs in 24-hour mode and is fully monitored; dut_b shares the same
// stimulus in 12-hour mode and is checked only at probe points.
module tb_clock_hms_counter;

    typedef struct {
        string      name;
        int         cyc;
        logic [23:0] dig;
        logic [4:0]  flg;   // {alarm_hit, load_err, tick_hr, tick_min, tick_sec}
        bit          chk12;
        logic [7:0]  hr12;
        logic [1:0]  f12;   // {load_err, tick_hr} of dut_b
    } rec_t;

    logic       clk = 1'b0;
    logic       reset_p, run, clear, load;
    logic [7:0] ld_sec, ld_min, ld_hr;
    logic [3:0] sec1_a, sec10_a, min1_a, min10_a, hr1_a, hr10_a;
    logic [3:0] sec1_b, sec10_b, min1_b, min10_b, hr1_b, hr10_b;
    logic       tsec_a, tmin_a, thr_a, lerr_a;
    logic       tsec_b, tmin_b, thr_b, lerr_b;
    logic       ah_a;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    rec_t ev_q[$];
    rec_t pr_q[$];

`ifdef CLOCK_HMS_ALARM_EN
    logic       alarm_on, alarm_set;
    logic [7:0] al_min, al_hr;
    logic       alarm_hit_a, alarm_hit_b;
    assign ah_a = alarm_hit_a;
`else
    assign ah_a = 1'b0;
`endif

    clock_hms_counter #(.SYS_CLK_HZ(10), .TICK_HZ(1), .HOUR_MAX(24)) dut_a (
        .clk(clk), .reset_p(reset_p), .run(run), .clear(clear), .load(load),
        .ld_sec(ld_sec), .ld_min(ld_min), .ld_hr(ld_hr),
`ifdef CLOCK_HMS_ALARM_EN
        .alarm_on(alarm_on), .alarm_set(alarm_set), .al_min(al_min), .al_hr(al_hr),
        .alarm_hit(alarm_hit_a),
`endif
        .sec1(sec1_a), .sec10(sec10_a), .min1(min1_a), .min10(min10_a),
        .hr1(hr1_a), .hr10(hr10_a),
        .tick_sec(tsec_a), .tick_min(tmin_a), .tick_hr(thr_a), .load_err(lerr_a)
    );

    clock_hms_counter #(.SYS_CLK_HZ(10), .TICK_HZ(1), .HOUR_MAX(12)) dut_b (
        .clk(clk), .reset_p(reset_p), .run(run), .clear(clear), .load(load),
        .ld_sec(ld_sec), .ld_min(ld_min), .ld_hr(ld_hr),
`ifdef CLOCK_HMS_ALARM_EN
        .alarm_on(alarm_on), .alarm_set(alarm_set), .al_min(al_min), .al_hr(al_hr),
        .alarm_hit(alarm_hit_b),
`endif
        .sec1(sec1_b), .sec10(sec10_b), .min1(min1_b), .min10(min10_b),
        .hr1(hr1_b), .hr10(hr10_b),
        .tick_sec(tsec_b), .tick_min(tmin_b), .tick_hr(thr_b), .load_err(lerr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [23:0] dig_a;
    logic [4:0]  flg_a;
    assign dig_a = {hr10_a, hr1_a, min10_a, min1_a, sec10_a, sec1_a};
    assign flg_a = {ah_a, lerr_a, thr_a, tmin_a, tsec_a};

    // Monitor: any pulse on dut_a pops the next expected event; probes fire on their cycle
    always @(negedge clk) begin
        rec_t r;
        if (flg_a != 5'b0) begin
            checks++;
            if (ev_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_event: cyc=%0d dig=%h flags=%b, required no event",
                         cyc, dig_a, flg_a);
            end else begin
                r = ev_q.pop_front();
                if (r.cyc != cyc || r.dig != dig_a || r.flg != flg_a) begin
                    errors++;
                    $display("FAIL %s: got cyc=%0d dig=%h flags=%b, required cyc=%0d dig=%h flags=%b",
                             r.name, cyc, dig_a, flg_a, r.cyc, r.dig, r.flg);
                end
            end
        end
        if (pr_q.size() != 0 && pr_q[0].cyc == cyc) begin
            r = pr_q.pop_front();
            checks++;
            if (r.dig != dig_a || r.flg != flg_a ||
                (r.chk12 && ({hr10_b, hr1_b} != r.hr12 || {lerr_b, thr_b} != r.f12))) begin
                errors++;
                $display("FAIL %s: got dig=%h flags=%b hr12=%h f12=%b, required dig=%h flags=%b hr12=%h f12=%b",
                         r.name, dig_a, flg_a, {hr10_b, hr1_b}, {lerr_b, thr_b},
                         r.dig, r.flg, r.hr12, r.f12);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input string n, input int c, input logic [23:0] d,
                           input logic [4:0] f);
        rec_t r;
        r.name = n; r.cyc = c; r.dig = d; r.flg = f;
        r.chk12 = 1'b0; r.hr12 = 8'h00; r.f12 = 2'b00;
        ev_q.push_back(r);
    endtask

    task automatic push_pr(input string n, input int c, input logic [23:0] d,
                           input logic [4:0] f, input bit k, input logic [7:0] h12,
                           input logic [1:0] f12);
        rec_t r;
        r.name = n; r.cyc = c; r.dig = d; r.flg = f;
        r.chk12 = k; r.hr12 = h12; r.f12 = f12;
        pr_q.push_back(r);
    endtask

    // One-cycle load strobe issued just after a clock edge
    task automatic do_load(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
        ld_hr = h; ld_min = m; ld_sec = s; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    // Rollover vectors: loaded time, time after one tick, expected pulses
    typedef struct {
        string       name;
        logic [23:0] ld;
        logic [23:0] exp;
        logic [4:0]  flg;
        bit          chk12;
    } vec_t;

    vec_t vecs[7] = '{
        '{"sec_units",   24'h000008, 24'h000009, 5'b00001, 1'b0},
        '{"sec_tens",    24'h000009, 24'h000010, 5'b00001, 1'b0},
        '{"min_carry",   24'h010959, 24'h011000, 5'b00011, 1'b0},
        '{"hr_units",    24'h095959, 24'h100000, 5'b00111, 1'b0},
        '{"hr_tens",     24'h195959, 24'h200000, 5'b00111, 1'b0},
        '{"day_wrap24",  24'h235959, 24'h000000, 5'b00111, 1'b0},
        '{"wrap12",      24'h115959, 24'h120000, 5'b00111, 1'b1}
    };

    initial begin
        int t;
        reset_p = 1'b1; run = 1'b0; clear = 1'b0; load = 1'b0;
        ld_sec = 8'h00; ld_min = 8'h00; ld_hr = 8'h00;
`ifdef CLOCK_HMS_ALARM_EN
        alarm_on = 1'b0; alarm_set = 1'b0; al_min = 8'h00; al_hr = 8'h00;
`endif
        step();
        // Load asserted during reset must be ignored
        ld_hr = 8'h12; ld_min = 8'h34; ld_sec = 8'h56; load = 1'b1;
        step();
        push_pr("reset_hold", cyc, 24'h000000, 5'b0, 1'b1, 8'h00, 2'b00);
        step();
        load = 1'b0;

        // First tick a full DIV after release
        t = cyc;
        reset_p = 1'b0; run = 1'b1;
        push_ev("first_tick", t + 10, 24'h000001, 5'b00001);
        repeat (10) step();

        // Rejected loads: time and prescaler untouched
        push_ev("bad_sec", cyc + 1, 24'h000001, 5'b01000);
        do_load(8'h05, 8'h12, 8'h60);
        push_ev("bad_min_units", cyc + 1, 24'h000001, 5'b01000);
        do_load(8'h05, 8'h5A, 8'h00);
        push_ev("bad_hr24", cyc + 1, 24'h000001, 5'b01000);
        do_load(8'h24, 8'h00, 8'h00);
        // Hour 12 is legal in 24 mode, rejected in 12 mode
        push_pr("hr12_reject", cyc + 1, 24'h123456, 5'b0, 1'b1, 8'h00, 2'b10);
        do_load(8'h12, 8'h34, 8'h56);

        // Carry chain vectors
        foreach (vecs[i]) begin
            t = cyc;
            push_ev(vecs[i].name, t + 11, vecs[i].exp, vecs[i].flg);
            if (vecs[i].chk12)
                push_pr("wrap12_b", t + 11, vecs[i].exp, vecs[i].flg, 1'b1, 8'h00, 2'b01);
            do_load(vecs[i].ld[23:16], vecs[i].ld[15:8], vecs[i].ld[7:0]);
            repeat (10) step();
        end

        // clear beats load (load value is illegal for dut_b: still no load_err)
        push_pr("clear_wins", cyc + 1, 24'h000000, 5'b0, 1'b1, 8'h00, 2'b00);
        clear = 1'b1;
        do_load(8'h23, 8'h59, 8'h59);
        clear = 1'b0;

        // Hold prescaler at 4 for 50 clks, then 6 clks to the tick
        do_load(8'h00, 8'h00, 8'h36);
        repeat (4) step();
        run = 1'b0;
        repeat (50) step();
        run = 1'b1;
        push_ev("resume_after_hold", cyc + 6, 24'h000037, 5'b00001);
        repeat (6) step();
        repeat (7) step();

        // Asynchronous reset at 00:00:37, prescaler 7, with a load pending
        ld_hr = 8'h01; ld_min = 8'h02; ld_sec = 8'h03; load = 1'b1;
        reset_p = 1'b1;
        push_pr("async_reset", cyc, 24'h000000, 5'b0, 1'b1, 8'h00, 2'b00);
        step();
        step();
        load = 1'b0;
        reset_p = 1'b0;
        push_ev("post_reset_tick", cyc + 10, 24'h000001, 5'b00001);
        repeat (10) step();

`ifdef CLOCK_HMS_ALARM_EN
        al_hr = 8'h00; al_min = 8'h01; alarm_set = 1'b1;
        step();
        // Illegal alarm: load_err, stored 00:01 kept
        al_min = 8'h60;
        push_ev("bad_alarm", cyc + 1, 24'h000001, 5'b01000);
        step();
        alarm_set = 1'b0;
        alarm_on = 1'b1;
        t = cyc;
        push_ev("alarm_tick", t + 11, 24'h000100, 5'b00011);
        push_ev("alarm_hit", t + 12, 24'h000100, 5'b10000);
        do_load(8'h00, 8'h00, 8'h59);
        repeat (11) step();
        alarm_on = 1'b0;
        push_ev("alarm_off_tick", cyc + 11, 24'h000100, 5'b00011);
        do_load(8'h00, 8'h00, 8'h59);
        repeat (12) step();
`endif

        repeat (3) step();
        while (ev_q.size() != 0) begin
            rec_t r;
            r = ev_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: event never seen, required cyc=%0d dig=%h flags=%b",
                     r.name, r.cyc, r.dig, r.flg);
        end
        while (pr_q.size() != 0) begin
            rec_t r;
            r = pr_q.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: probe never taken, required cyc=%0d", r.name, r.cyc);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
